// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default field limits for the stopwatch time core.
package stopwatch_pkg;

  localparam int unsigned SEC_MAX_D = 59;
  localparam int unsigned MIN_MAX_D = 59;
  localparam int unsigned SEC_W_D   = 6;
  localparam int unsigned MIN_W_D   = 6;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

endpackage

// File: rtl/stopwatch_time_ctrl_if.sv
// Control/status bundle between the tick/button front end and the time core.
interface stopwatch_time_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_W = SEC_W_D,
  parameter int unsigned MIN_W = MIN_W_D
);

  logic             tick_1hz;
  logic             tick_2hz;
  logic             pause_tog;
  logic             adj;
  logic             sel;
  logic             down;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic             running;
  logic             wrap;

  modport master (
    output tick_1hz, tick_2hz, pause_tog, adj, sel, down,
    input  minutes, seconds, running, wrap
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_tog, adj, sel, down,
    output minutes, seconds, running, wrap
  );

endinterface

// File: rtl/stopwatch_time_ctrl_mod_counter.sv
// Modulo-(MAX+1) up/down counter; carry flags the step that wraps the field.
module mod_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dn,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (en) begin
      if (dn) begin
        value_d = (value_q == '0) ? W'(MAX) : W'(value_q - W'(1));
      end else begin
        // Values above MAX cannot occur, but fold them back to zero anyway.
        value_d = (value_q >= W'(MAX)) ? '0 : W'(value_q + W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign carry = en & (dn ? (value_q == '0) : (value_q == W'(MAX)));
  assign value = value_q;

endmodule

// File: rtl/stopwatch_time_ctrl.sv
// Minutes/seconds core: run/pause/adjust FSM, chained field counters, wrap pulse.
module stopwatch_time_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_MAX = SEC_MAX_D,
  parameter int unsigned MIN_MAX = MIN_MAX_D,
  parameter int unsigned SEC_W   = SEC_W_D,
  parameter int unsigned MIN_W   = MIN_W_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stopwatch_time_ctrl_if.slave bus
);

  if (SEC_MAX >= (64'd1 << SEC_W)) begin : g_bad_sec_w
    $error("SEC_MAX does not fit in SEC_W bits");
  end
  if (MIN_MAX >= (64'd1 << MIN_W)) begin : g_bad_min_w
    $error("MIN_MAX does not fit in MIN_W bits");
  end

  state_e state_q, state_d;
  logic   run_saved_q, run_saved_d;
  logic   running_q, running_d;
  logic   wrap_q, wrap_d;

  logic             sec_en, min_en;
  logic             sec_carry, min_carry;
  logic [SEC_W-1:0] sec_value;
  logic [MIN_W-1:0] min_value;

  // Mode transitions; adj outranks pause_tog, which then only edits run_saved.
  always_comb begin
    state_d     = state_q;
    run_saved_d = run_saved_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.adj) begin
          state_d     = ST_ADJUST;
          run_saved_d = ~bus.pause_tog;
        end else if (bus.pause_tog) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (bus.adj) begin
          state_d     = ST_ADJUST;
          run_saved_d = bus.pause_tog;
        end else if (bus.pause_tog) begin
          state_d = ST_RUN;
        end
      end
      ST_ADJUST: begin
        if (bus.pause_tog) run_saved_d = ~run_saved_q;
        if (!bus.adj)      state_d     = run_saved_d ? ST_RUN : ST_PAUSED;
      end
      default: state_d = ST_RUN;
    endcase
    running_d = (state_d == ST_RUN);
  end

  // Counting uses the pre-transition state; adjust steps one field with no carry.
  always_comb begin
    sec_en = 1'b0;
    min_en = 1'b0;
    wrap_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        sec_en = bus.tick_1hz;
        min_en = sec_carry;
        wrap_d = sec_carry & min_carry;
      end
      ST_ADJUST: begin
        sec_en = bus.tick_2hz & bus.sel;
        min_en = bus.tick_2hz & ~bus.sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      run_saved_q <= 1'b1;
      running_q   <= 1'b1;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_saved_q <= run_saved_d;
      running_q   <= running_d;
      wrap_q      <= wrap_d;
    end
  end

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .dn    (bus.down),
    .value (sec_value),
    .carry (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_en),
    .dn    (bus.down),
    .value (min_value),
    .carry (min_carry)
  );

  assign bus.seconds = sec_value;
  assign bus.minutes = min_value;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_ctrl.sv
// Directed bench for stopwatch_time_ctrl: default 59:59 core plus a 05:09 variant.
module tb_stopwatch_time_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stopwatch_time_ctrl_if #(.SEC_W(6), .MIN_W(6)) ifa ();
  stopwatch_time_ctrl_if #(.SEC_W(4), .MIN_W(3)) ifb ();

  stopwatch_time_ctrl #(.SEC_MAX(59), .MIN_MAX(59), .SEC_W(6), .MIN_W(6)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  stopwatch_time_ctrl #(.SEC_MAX(9), .MIN_MAX(5), .SEC_W(4), .MIN_W(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int m, input int s, input int run, input int wr);
    check_eq({tag, ".min"}, 32'(ifa.minutes), 32'(m));
    check_eq({tag, ".sec"}, 32'(ifa.seconds), 32'(s));
    check_eq({tag, ".running"}, 32'(ifa.running), 32'(run));
    check_eq({tag, ".wrap"}, 32'(ifa.wrap), 32'(wr));
  endtask

  task automatic tick1_a();
    ifa.tick_1hz = 1'b1; step(); ifa.tick_1hz = 1'b0;
  endtask

  task automatic tick2_a();
    ifa.tick_2hz = 1'b1; step(); ifa.tick_2hz = 1'b0;
  endtask

  task automatic ptog_a();
    ifa.pause_tog = 1'b1; step(); ifa.pause_tog = 1'b0;
  endtask

  initial begin
    ifa.tick_1hz = 0; ifa.tick_2hz = 0; ifa.pause_tog = 0;
    ifa.adj = 0; ifa.sel = 0; ifa.down = 0;
    ifb.tick_1hz = 0; ifb.tick_2hz = 0; ifb.pause_tog = 0;
    ifb.adj = 0; ifb.sel = 0; ifb.down = 0;
    rst_n = 1'b0;

    step();
    chk_a("reset", 0, 0, 1, 0);
    rst_n = 1'b1;

    for (int i = 1; i <= 60; i++) begin
      tick1_a();
      chk_a($sformatf("count_up%0d", i), i / 60, i % 60, 1, 0);
    end

    // Preload 59:58 through ADJUST
    ifa.adj = 1; step();
    check_eq("adj_enter.running", 32'(ifa.running), 0);
    ifa.sel = 0; ifa.down = 1;
    tick2_a(); tick2_a();
    chk_a("adj_min_borrowless", 59, 0, 0, 0);
    ifa.sel = 1;
    tick2_a(); tick2_a();
    chk_a("adj_sec_no_borrow", 59, 58, 0, 0);
    ifa.adj = 0; ifa.down = 0; step();
    chk_a("adj_exit_run", 59, 58, 1, 0);
    tick1_a();
    chk_a("pre_wrap", 59, 59, 1, 0);
    tick1_a();
    chk_a("wrap_up", 0, 0, 1, 1);
    step();
    chk_a("wrap_up_clear", 0, 0, 1, 0);
    ifa.down = 1;
    tick1_a();
    chk_a("wrap_down", 59, 59, 1, 1);
    step();
    chk_a("wrap_down_clear", 59, 59, 1, 0);
    ifa.down = 0;
    tick1_a();
    chk_a("wrap_up2", 0, 0, 1, 1);

    for (int i = 0; i < 10; i++) tick1_a();
    chk_a("at_0010", 0, 10, 1, 0);
    ptog_a();
    chk_a("pause", 0, 10, 0, 0);
    for (int i = 0; i < 5; i++) tick1_a();
    chk_a("paused_ticks", 0, 10, 0, 0);
    ptog_a();
    chk_a("resume", 0, 10, 1, 0);
    tick1_a();
    chk_a("resume_tick", 0, 11, 1, 0);

    // Seconds wrap in ADJUST without touching minutes
    ifa.adj = 1; step();
    ifa.sel = 1; ifa.down = 1;
    for (int i = 0; i < 12; i++) tick2_a();
    chk_a("adj_sec_0059", 0, 59, 0, 0);
    ifa.down = 0;
    tick2_a();
    chk_a("adj_sec_wrap", 0, 0, 0, 0);
    tick1_a();
    chk_a("adj_ignore_1hz", 0, 0, 0, 0);
    ifa.sel = 0; ifa.down = 1;
    tick2_a();
    chk_a("adj_min_5900", 59, 0, 0, 0);
    tick2_a();
    chk_a("adj_min_5800", 58, 0, 0, 0);
    ifa.adj = 0; ifa.down = 0; step();
    chk_a("adj_back_run", 58, 0, 1, 0);

    // PAUSED -> ADJUST, toggle run_saved, back to RUN
    ptog_a();
    ifa.adj = 1; step();
    ptog_a();
    check_eq("adj_from_pause.running", 32'(ifa.running), 0);
    ifa.adj = 0; step();
    chk_a("pause_adj_tog_run", 58, 0, 1, 0);

    ifa.adj = 1; ifa.pause_tog = 1; step(); ifa.pause_tog = 0;
    check_eq("adj_prio.running", 32'(ifa.running), 0);
    ifa.adj = 0; step();
    chk_a("adj_prio_paused", 58, 0, 0, 0);
    tick1_a();
    chk_a("adj_prio_frozen", 58, 0, 0, 0);
    ptog_a();
    chk_a("adj_prio_resume", 58, 0, 1, 0);

    ifa.pause_tog = 1; tick1_a(); ifa.pause_tog = 0;
    chk_a("tick_and_pause", 58, 1, 0, 0);
    tick1_a();
    chk_a("tick_and_pause_frozen", 58, 1, 0, 0);
    ptog_a();
    ifa.adj = 1; tick1_a();
    chk_a("tick_and_adj", 58, 2, 0, 0);

    // Set 12:34 in ADJUST, then reset with a competing tick
    ifa.sel = 0; ifa.down = 0;
    for (int i = 0; i < 14; i++) tick2_a();
    ifa.sel = 1;
    for (int i = 0; i < 32; i++) tick2_a();
    chk_a("adj_1234", 12, 34, 0, 0);
    rst_n = 0; ifa.tick_2hz = 1; step(); ifa.tick_2hz = 0;
    chk_a("mid_reset", 0, 0, 1, 0);
    rst_n = 1; ifa.adj = 0;

    // Reduced-limit instance wraps at 05:09
    for (int i = 1; i <= 60; i++) begin
      ifb.tick_1hz = 1; step(); ifb.tick_1hz = 0;
      if (i == 10) begin
        check_eq("b_0100.min", 32'(ifb.minutes), 1);
        check_eq("b_0100.sec", 32'(ifb.seconds), 0);
      end
      if (i == 59) begin
        check_eq("b_0509.min", 32'(ifb.minutes), 5);
        check_eq("b_0509.sec", 32'(ifb.seconds), 9);
        check_eq("b_0509.wrap", 32'(ifb.wrap), 0);
      end
    end
    check_eq("b_wrap.min", 32'(ifb.minutes), 0);
    check_eq("b_wrap.sec", 32'(ifb.seconds), 0);
    check_eq("b_wrap.wrap", 32'(ifb.wrap), 1);
    step();
    check_eq("b_wrap_clear", 32'(ifb.wrap), 0);
    ifb.down = 1; ifb.tick_1hz = 1; step(); ifb.tick_1hz = 0;
    check_eq("b_down.min", 32'(ifb.minutes), 5);
    check_eq("b_down.sec", 32'(ifb.seconds), 9);
    check_eq("b_down.wrap", 32'(ifb.wrap), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_ctrl.md
Name: stopwatch_time_ctrl

Overview:
Parametrised minutes/seconds time-keeping core for the stopwatch, one generation on from the select/adjust logic. It keeps all state on the single system clock and is advanced by one-cycle enable ticks, not derived clocks. It adds run/pause control, up/down counting, configurable field limits and a wrap pulse. It sits between the tick generator and the display/BCD encoder.

Parameters:
SEC_MAX, 59, largest seconds value; the seconds field wraps SEC_MAX <-> 0.
MIN_MAX, 59, largest minutes value; the minutes field wraps MIN_MAX <-> 0.
SEC_W, 6, seconds field width; must satisfy SEC_MAX < 2**SEC_W.
MIN_W, 6, minutes field width; must satisfy MIN_MAX < 2**MIN_W.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  synchronous, active-low reset.
tick_1hz  in  1  one-cycle pulse, run-mode count enable.
tick_2hz  in  1  one-cycle pulse, adjust-mode step enable.
pause_tog  in  1  one-cycle pulse (already debounced upstream); toggles run/pause.
adj  in  1  level; 1 = adjust mode.
sel  in  1  level; adjust target, 1 = seconds, 0 = minutes.
down  in  1  level; 1 = decrement, 0 = increment (both modes).
minutes  out  MIN_W  current minutes value.
seconds  out  SEC_W  current seconds value.
running  out  1  1 when state is RUN.
wrap  out  1  one-cycle pulse on full-time rollover in RUN.

Behaviour:
- Reset (rst_n=0 at posedge): minutes=0, seconds=0, state=RUN, run_saved=1, running=1, wrap=0. Reset overrides every other input in the same cycle.
- States: RUN, PAUSED, ADJUST. running is a registered output equal to (state==RUN).
- RUN -> PAUSED on pause_tog. PAUSED -> RUN on pause_tog.
- RUN/PAUSED -> ADJUST when adj=1. On entry, run_saved records whether the state was RUN.
- ADJUST -> (run_saved ? RUN : PAUSED) in the cycle after adj returns to 0.
- pause_tog while in ADJUST toggles run_saved only.
- Adj has priority: adj=1 and pause_tog in the same cycle from RUN gives ADJUST with run_saved=0.
- RUN, tick_1hz, down=0: seconds+1. If seconds==SEC_MAX: seconds=0, minutes+1. If minutes==MIN_MAX too: both go to 0 and wrap=1 for one cycle.
- RUN, tick_1hz, down=1: seconds-1. If seconds==0: seconds=SEC_MAX, minutes-1. At 00:00: go to MIN_MAX:SEC_MAX and wrap=1.
- In RUN, tick_2hz is ignored.
- PAUSED: value frozen; all ticks ignored.
- ADJUST: tick_1hz ignored. On tick_2hz, step the field chosen by sel (+1 or -1 per down), wrapping modulo its MAX+1, with no carry or borrow into the other field. wrap is never asserted in ADJUST.
- Timing: outputs update on the posedge where the tick is sampled (1 cycle latency from tick to output).
- Simultaneous events in RUN: a tick_1hz and pause_tog in the same cycle apply the count, then enter PAUSED. A tick in the same cycle as adj rising uses the pre-transition state (RUN counts).
- sel/down changes take effect at the next tick; no glitch or extra step.
- Out-of-range values are unreachable. An implementation may treat >MAX as wrap-to-0 on increment.

Decomposition:
- Package stopwatch_pkg: state encoding (ST_RUN, ST_PAUSED, ST_ADJUST, 2-bit) and default limit constants SEC_MAX_D=59, MIN_MAX_D=59.
- Sub-module mod_counter #(MAX, W): ports clk, rst_n, en, dn, value, carry. carry is combinational and set when en and value is at its wrap point in direction dn. Instantiate it twice.
- Run-mode chaining: minutes en = seconds carry. Adjust mode gates the carry off.
- The FSM and wrap register live in the top.

Test Plan:
- Reset, then 60 tick_1hz pulses with down=0 -> seconds 0..59 then 00:01:00 exactly; running=1 throughout.
- Preload 59:58 via ADJUST, return to RUN, 2 ticks -> 59:59 then 00:00, wrap=1 for exactly one cycle. Repeat with down=1 from 00:00 -> 59:59, wrap=1.
- RUN at 00:10, pause_tog -> running=0; 5 ticks -> still 00:10; pause_tog -> next tick gives 00:11.
- ADJUST sel=1 at 00:59, tick_2hz -> 00:00 with minutes unchanged. sel=0 at 59:00, down=1, tick_2hz -> 58:00. tick_1hz in ADJUST has no effect.
- From PAUSED, adj=1, pause_tog, adj=0 -> returns to RUN. Same cycle adj=1+pause_tog from RUN -> ADJUST, then adj=0 -> PAUSED.
- rst_n=0 mid-count at 12:34 in ADJUST -> next posedge 00:00, RUN, wrap=0. Rerun with SEC_MAX=9, MIN_MAX=5, widths 4/3 -> wrap at 05:09.
